// File: rtl/mix_input_controller.sv
// Input staging register for the MIX1..MIX3 layers: transposes the producing
// layer's output and optionally adds a noise row vector on the MIX3 input.
// Optional feature: define MIX_IN_SAT_EN to saturate the noise add instead of wrapping.
module mix_input_controller #(
  parameter int HID_DIM   = 4,
  parameter int N         = HID_DIM,
  parameter int EMB_DIM   = HID_DIM,
  parameter int N_LEN     = 16,
  parameter int STATE_LEN = 3,
  parameter int MODE_LEN  = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [STATE_LEN-1:0]               state,
  input  logic [MODE_LEN-1:0]                mode,
  input  logic [N*EMB_DIM*N_LEN-1:0]         d_emb,
  input  logic [HID_DIM*HID_DIM*N_LEN-1:0]   d_mix,
  input  logic [HID_DIM*N_LEN-1:0]           d_rand,
  input  logic                               valid_emb,
  input  logic                               valid_mix,
  input  logic                               valid_rand,
  output logic                               valid,
  output logic [HID_DIM*HID_DIM*N_LEN-1:0]   q
);

  // Global pipeline state and mode codes shared with the rest of the generator.
  localparam logic [STATE_LEN-1:0] IDLE = STATE_LEN'(0);
  localparam logic [STATE_LEN-1:0] EMB  = STATE_LEN'(1);
  localparam logic [STATE_LEN-1:0] MIX1 = STATE_LEN'(2);
  localparam logic [STATE_LEN-1:0] MIX2 = STATE_LEN'(3);
  localparam logic [STATE_LEN-1:0] MIX3 = STATE_LEN'(4);
  localparam logic [STATE_LEN-1:0] DENS = STATE_LEN'(5);
  localparam logic [MODE_LEN-1:0]  GEN_SIMI = MODE_LEN'(1);

  localparam int QW = HID_DIM * HID_DIM * N_LEN;

  logic          cap_emb;
  logic          cap_mix1;
  logic          cap_mix2;
  logic          capture;
  logic          noise_en;
  logic [QW-1:0] q_next;

  // Only the strobe matching the current state counts; all others are ignored.
  assign cap_emb  = (state == EMB)  && valid_emb;
  assign cap_mix1 = (state == MIX1) && valid_mix;
  assign cap_mix2 = (state == MIX2) && valid_mix;
  assign capture  = cap_emb || cap_mix1 || cap_mix2;
  assign noise_en = cap_mix2 && (mode == GEN_SIMI) && valid_rand;

  function automatic logic [N_LEN-1:0] add_noise(input logic [N_LEN-1:0] a,
                                                 input logic [N_LEN-1:0] b);
    logic [N_LEN-1:0] sum;
    sum = a + b;
`ifdef MIX_IN_SAT_EN
    // Signed overflow only when both operands share a sign the result lacks.
    if ((a[N_LEN-1] == b[N_LEN-1]) && (sum[N_LEN-1] != a[N_LEN-1])) begin
      sum = a[N_LEN-1] ? {1'b1, {(N_LEN-1){1'b0}}} : {1'b0, {(N_LEN-1){1'b1}}};
    end
`endif
    return sum;
  endfunction

  // Source (r,c) lands on q (c,r); that q element's column is r, so it takes d_rand[r].
  always_comb begin
    q_next = '0;
    for (int r = 0; r < HID_DIM; r++) begin
      for (int c = 0; c < HID_DIM; c++) begin
        if (noise_en) begin
          q_next[(c*HID_DIM+r)*N_LEN +: N_LEN] =
            add_noise(d_mix[(r*HID_DIM+c)*N_LEN +: N_LEN], d_rand[r*N_LEN +: N_LEN]);
        end else if (cap_emb) begin
          q_next[(c*HID_DIM+r)*N_LEN +: N_LEN] = d_emb[(r*EMB_DIM+c)*N_LEN +: N_LEN];
        end else begin
          q_next[(c*HID_DIM+r)*N_LEN +: N_LEN] = d_mix[(r*HID_DIM+c)*N_LEN +: N_LEN];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= capture;
      if (capture) begin
        q <= q_next;
      end
    end
  end

  // IDLE, MIX3 and DENS never capture; named here so the code map stays complete.
  logic unused_states;
  assign unused_states = (state == IDLE) ^ (state == MIX3) ^ (state == DENS);
  logic unused;
  assign unused = unused_states;

endmodule

// File: tb/tb_mix_input_controller.sv
// Directed and randomized bench for mix_input_controller against a matrix-level
// reference model (2D arrays, integer add with wrap or clamp).
module tb_mix_input_controller;

  localparam int H  = 4;
  localparam int NL = 16;
  localparam int QW = H * H * NL;
  localparam int RW = H * NL;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EMB  = 3'd1;
  localparam logic [2:0] S_MIX1 = 3'd2;
  localparam logic [2:0] S_MIX2 = 3'd3;
  localparam logic [2:0] S_MIX3 = 3'd4;
  localparam logic [2:0] S_DENS = 3'd5;
  localparam logic [1:0] M_SIMI = 2'd1;

  logic          clk;
  logic          rst_n;
  logic [2:0]    state;
  logic [1:0]    mode;
  logic [QW-1:0] d_emb;
  logic [QW-1:0] d_mix;
  logic [RW-1:0] d_rand;
  logic          valid_emb;
  logic          valid_mix;
  logic          valid_rand;
  logic          valid;
  logic [QW-1:0] q;

  mix_input_controller dut (
    .clk(clk), .rst_n(rst_n), .state(state), .mode(mode),
    .d_emb(d_emb), .d_mix(d_mix), .d_rand(d_rand),
    .valid_emb(valid_emb), .valid_mix(valid_mix), .valid_rand(valid_rand),
    .valid(valid), .q(q)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [NL-1:0] emb_m [H][H];
  logic [NL-1:0] mix_m [H][H];
  logic [NL-1:0] rand_v [H];
  logic [NL-1:0] cur_m [H][H];
  logic [QW-1:0] exp_q [$];
  logic          exp_valid;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [QW-1:0] pack_mat(input logic [NL-1:0] m [H][H]);
    logic [QW-1:0] v;
    v = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < H; c++)
        v[(r*H+c)*NL +: NL] = m[r][c];
    return v;
  endfunction

  function automatic logic [NL-1:0] q_el(input int r, input int c);
    return q[(r*H+c)*NL +: NL];
  endfunction

  function automatic logic [NL-1:0] noisy(input logic [NL-1:0] a, input logic [NL-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef MIX_IN_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return NL'(s);
  endfunction

  task automatic clear_model();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < H; c++)
        cur_m[r][c] = '0;
    exp_q.delete();
  endtask

  task automatic randomize_data();
    for (int r = 0; r < H; r++) begin
      rand_v[r] = NL'($urandom);
      for (int c = 0; c < H; c++) begin
        emb_m[r][c] = NL'($urandom);
        mix_m[r][c] = NL'($urandom);
      end
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, check at the next negedge
  task automatic step(input string tag, input logic [2:0] s, input logic [1:0] m,
                      input logic ve, input logic vm, input logic vr);
    bit cap;
    bit noise;
    state = s; mode = m; valid_emb = ve; valid_mix = vm; valid_rand = vr;
    d_emb = pack_mat(emb_m);
    d_mix = pack_mat(mix_m);
    for (int r = 0; r < H; r++) d_rand[r*NL +: NL] = rand_v[r];
    cap   = (s == S_EMB && ve) || ((s == S_MIX1 || s == S_MIX2) && vm);
    noise = (s == S_MIX2) && vm && (m == M_SIMI) && vr;
    if (cap) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < H; c++) begin
          logic [NL-1:0] src;
          src = (s == S_EMB) ? emb_m[r][c] : mix_m[r][c];
          cur_m[c][r] = noise ? noisy(src, rand_v[r]) : src;
        end
      exp_q.push_back(pack_mat(cur_m));
    end
    exp_valid = cap;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, QW'(valid), QW'(exp_valid));
    if (exp_valid && exp_q.size() > 0) chk({tag, "_q"}, q, exp_q.pop_front());
    else chk({tag, "_hold"}, q, pack_mat(cur_m));
  endtask

  initial begin
    state = S_EMB; mode = M_SIMI; valid_emb = 1'b1; valid_mix = 1'b1; valid_rand = 1'b1;
    d_emb = '1; d_mix = '1; d_rand = '1;
    exp_valid = 1'b0;
    rst_n = 1'b1;
    clear_model();
    randomize_data();

    // reset with all strobes high, before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_q_async", q, '0);
    chk("rst_valid_async", QW'(valid), '0);
    @(negedge clk);
    chk("rst_q_edge", q, '0);
    chk("rst_valid_edge", QW'(valid), '0);
    rst_n = 1'b1;

    // EMB transpose
    randomize_data();
    emb_m[0][1] = 16'h0005;
    emb_m[1][0] = 16'h0003;
    step("emb", S_EMB, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("emb_q10", QW'(q_el(1, 0)), QW'(16'h0005));
    chk("emb_q01", QW'(q_el(0, 1)), QW'(16'h0003));
    step("emb_hold_mix1", S_MIX1, 2'd0, 1'b0, 1'b0, 1'b0);

    // MIX2 input: no noise even with GEN_SIMI and valid_rand
    randomize_data();
    step("mix1_cap", S_MIX1, M_SIMI, 1'b0, 1'b1, 1'b1);
    step("mix1_after", S_MIX1, M_SIMI, 1'b0, 1'b0, 1'b1);

    // MIX3 input with and without noise
    randomize_data();
    for (int r = 0; r < H; r++) rand_v[r] = 16'hFFFC;
    mix_m[2][0] = 16'h0010;
    step("mix2_noise", S_MIX2, M_SIMI, 1'b0, 1'b1, 1'b1);
    chk("noise_q02", QW'(q_el(0, 2)), QW'(16'h000C));
    step("mix2_mode_off", S_MIX2, 2'd2, 1'b0, 1'b1, 1'b1);
    chk("mode_off_q02", QW'(q_el(0, 2)), QW'(16'h0010));
    step("mix2_rand_off", S_MIX2, M_SIMI, 1'b0, 1'b1, 1'b0);
    chk("rand_off_q02", QW'(q_el(0, 2)), QW'(16'h0010));

    // overflow on the noise add; per-row noise values distinguish the column mapping
    randomize_data();
    for (int r = 0; r < H; r++) rand_v[r] = NL'(r);
    rand_v[1] = 16'h0005;
    mix_m[1][2] = 16'h7FFE;
    step("mix2_ovf", S_MIX2, M_SIMI, 1'b0, 1'b1, 1'b1);
`ifdef MIX_IN_SAT_EN
    chk("ovf_q21", QW'(q_el(2, 1)), QW'(16'h7FFF));
`else
    chk("ovf_q21", QW'(q_el(2, 1)), QW'(16'h8003));
`endif

    // ignored strobes
    randomize_data();
    step("ign_mix_emb", S_EMB, M_SIMI, 1'b0, 1'b1, 1'b1);
    step("ign_mix_mix3", S_MIX3, M_SIMI, 1'b1, 1'b1, 1'b1);
    step("ign_mix_dens", S_DENS, M_SIMI, 1'b1, 1'b1, 1'b1);
    step("ign_mix_idle", S_IDLE, M_SIMI, 1'b1, 1'b1, 1'b1);
    step("ign_emb_mix1", S_MIX1, M_SIMI, 1'b1, 1'b0, 1'b1);

    // both strobes in EMB: the embedding strobe wins
    step("both_emb", S_EMB, M_SIMI, 1'b1, 1'b1, 1'b1);

    // back-to-back captures with fresh data
    randomize_data();
    step("b2b_0", S_MIX1, 2'd0, 1'b0, 1'b1, 1'b0);
    randomize_data();
    step("b2b_1", S_MIX1, 2'd0, 1'b0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      randomize_data();
      step("rand", 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset mid-operation, then a strobe held during reset is lost
    randomize_data();
    step("pre_rst", S_MIX1, 2'd0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("midrst_q", q, '0);
    chk("midrst_valid", QW'(valid), '0);
    state = S_EMB; valid_emb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_strobe_q", q, '0);
    chk("midrst_strobe_valid", QW'(valid), '0);
    rst_n = 1'b1;
    step("post_rst_idle", S_IDLE, 2'd0, 1'b0, 1'b0, 1'b0);
    randomize_data();
    step("post_rst_emb", S_EMB, 2'd0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
